decoder_seq_n: RTL and testbench
================================

# decoder_seq_n

Registered, parametrised binary-to-one-hot decoder that succeeds the combinational 3:8 decoder. It adds a free-running scan mode that steps the one-hot output through all 2^SEL_W lines, holding each line for a programmable dwell. It sits in front of chip-select, LED-multiplex and row-strobe logic, where the direct mode replaces the old decoder and the scan mode replaces ad-hoc select counters.

## Interface
- SEL_W, 3, select width; OUTS = 2^SEL_W (derived localparam, not overridable); legal 1..6
- DWELL_W, 4, dwell count width
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset, sampled on clk rising edge
- en  in  1  block enable; 0 forces all outputs low on the next edge
- mode  in  1  0 = direct decode, 1 = scan
- in  in  SEL_W  direct-mode select; scan-mode start index
- load  in  1  scan-mode restart strobe; has no effect in direct mode
- dwell  in  DWELL_W  extra hold cycles per line in scan mode (each line held for dwell+1 cycles)
- out  out  OUTS  registered one-hot output, or all zero
- idx  out  SEL_W  binary index of the asserted line
- valid  out  1  high whenever out is non-zero
- wrap  out  1  one-cycle pulse when scan steps from OUTS-1 to 0

## Operation
- States:
  - OFF: en=0.
  - DIRECT: en=1, mode=0.
  - SCAN: en=1, mode=1.
- The next state is chosen from {en, mode} every cycle.
- Reset (rst_n=0 at an edge):
  - State goes to OFF.
  - out=0, idx=0, valid=0, wrap=0, dwell counter=0.
  - Reset overrides all other inputs.
- OFF:
  - out=0, valid=0, wrap=0.
  - idx and the dwell counter clear to 0.
- DIRECT:
  - Each edge, out <= 1<<in, idx <= in, valid <= 1.
  - The dwell counter is held at 0.
  - wrap=0.
- SCAN entry (from OFF or DIRECT):
  - idx <= in, out <= 1<<in, valid <= 1.
  - The dwell counter is cleared and dwell is captured.
- SCAN steady state:
  - While counter < captured dwell: counter increments and out holds.
  - When counter = captured dwell: idx <= idx+1 modulo OUTS, counter <= 0, dwell is re-captured, and out follows idx.
  - A dwell change only takes effect at a line boundary.
  - wrap=1 in the same cycle that out becomes bit 0 by stepping from OUTS-1. Otherwise wrap=0.
  - Entry or load at index 0 does not pulse wrap.
- load=1 in SCAN:
  - Behaves like SCAN entry: idx <= in, counter cleared, dwell captured.
  - Takes priority over a concurrent step.
  - wrap=0 that cycle.
- Mode change while en=1:
  - SCAN to DIRECT decodes in on the next edge.
  - DIRECT to SCAN performs SCAN entry.
- Arithmetic:
  - idx increment is SEL_W bits and wraps naturally.
  - Counter is DWELL_W bits and never exceeds dwell, so it cannot overflow.
- Invariant: out is always exactly one-hot or zero, and out == (valid ? 1<<idx : 0).

## Timing
- All outputs are registered, with no combinational input-to-output path.
- Latency is one cycle: inputs sampled at edge k appear on the outputs after edge k.
- Scan period is OUTS*(dwell+1) cycles when dwell is constant.
- wrap is exactly one cycle wide. It recurs every OUTS*(dwell+1) cycles.
- en falling: outputs are zero after the next edge. en rising: the first line is asserted after the next edge.
- Reset mid-scan: outputs are zero after the reset edge. Scan restarts from in one edge after rst_n=1, provided en=1 and mode=1.

## Test plan
- Reset: hold rst_n=0 with en=1, mode=1, in=5 for 3 edges -> out=0x00, idx=0, valid=0, wrap=0 throughout.
- Direct sweep, SEL_W=3:
  - Stimulus: {en,in} from 0 to 15, one per cycle, mode=0.
  - Response: for en=0, out=0x00 one cycle later; for en=1, out=1<<in one cycle later (in=3 -> 0x08, in=7 -> 0x80), valid=1.
- Scan with dwell=0:
  - Stimulus: en=1, mode=1, in=6.
  - Response: out sequence 0x40, 0x80, 0x01 (wrap=1 on that cycle only), 0x02, ...
  - Bit 0 re-asserts with wrap=1 exactly 8 cycles after the first wrap.
- Scan with dwell=2, changed at run time:
  - Stimulus: start in=0 with dwell=2, so each line is held 3 cycles.
  - Change dwell to 0 in the middle of line 1.
  - Response: line 1 still lasts 3 cycles; line 2 onward lasts 1 cycle each.
- Load priority and mode switch:
  - Stimulus: load=1 with in=4 on the cycle scan would step 2->3; then mode=0 with in=1.
  - Response: out goes 0x04 to 0x10, with counter restarted and wrap=0; then out=0x02 on the next edge.
- Parameter and mid-scan reset:
  - Stimulus: SEL_W=4, dwell=0, full scan; then rst_n=0 at idx=9.
  - Response: 16 distinct lines with wrap every 16 cycles; out=0 on the reset edge; scan resumes from in after release.

Source files
------------

// File: rtl/decoder_seq_n.sv
// decoder_seq_n: registered binary-to-one-hot decoder with a scan mode.
//
// Direct mode decodes `in` onto the one-hot `out`. Scan mode steps the
// one-hot line through all OUTS positions, starting at `in`. Each line is
// held for dwell+1 cycles.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   en     block enable; 0 clears all outputs on the next edge
//   mode   0 = direct decode, 1 = scan
//   in     direct-mode select / scan-mode start index
//   load   scan-mode restart strobe (ignored in direct mode)
//   dwell  extra hold cycles per scanned line
//   out    registered one-hot output, or all zero
//   idx    binary index of the asserted line
//   valid  high whenever out is non-zero
//   wrap   one-cycle pulse when the scan steps from OUTS-1 to 0
module decoder_seq_n #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      in,
  input  logic                  load,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(1<<SEL_W)-1:0] out,
  output logic [SEL_W-1:0]      idx,
  output logic                  valid,
  output logic                  wrap
);

  localparam int OUTS = 1 << SEL_W;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_DIRECT,
    ST_SCAN
  } state_t;

  state_t              state_q, state_d;
  logic [OUTS-1:0]     out_q, out_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic                valid_q, valid_d;
  logic                wrap_q, wrap_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      out_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
    end
  end

  always_comb begin
    state_d = ST_OFF;
    idx_d   = '0;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    cnt_d   = '0;
    dwell_d = dwell_q;
    out_d   = '0;

    if (!en)
      state_d = ST_OFF;
    else if (mode)
      state_d = ST_SCAN;
    else
      state_d = ST_DIRECT;

    unique case (state_d)
      ST_OFF: begin
        idx_d   = '0;
        valid_d = 1'b0;
      end
      ST_DIRECT: begin
        idx_d   = in;
        valid_d = 1'b1;
      end
      ST_SCAN: begin
        valid_d = 1'b1;
        // Entry and load restart the line. This branch wins over a
        // pending step, so wrap stays low even when restarting at 0.
        if (state_q != ST_SCAN || load) begin
          idx_d   = in;
          dwell_d = dwell;
        end else if (cnt_q == dwell_q) begin
          // Line boundary: the only point where a new dwell is picked up.
          idx_d   = idx_q + SEL_W'(1);
          dwell_d = dwell;
          wrap_d  = &idx_q;
        end else begin
          idx_d   = idx_q;
          cnt_d   = cnt_q + DWELL_W'(1);
        end
      end
      default: begin
        idx_d   = '0;
        valid_d = 1'b0;
      end
    endcase

    if (valid_d)
      out_d[idx_d] = 1'b1;
  end

  assign out   = out_q;
  assign idx   = idx_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_decoder_seq_n.sv
// Directed testbench for decoder_seq_n. It uses an 8-line instance and a
// 16-line instance.
module tb_decoder_seq_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-line instance
  logic       rst_n, en, mode, load;
  logic [2:0] in;
  logic [3:0] dwell;
  logic [7:0] out;
  logic [2:0] idx;
  logic       valid, wrap;

  // 16-line instance
  logic        rst2_n, en2, mode2, load2;
  logic [3:0]  in2;
  logic [3:0]  dwell2;
  logic [15:0] out2;
  logic [3:0]  idx2;
  logic        valid2, wrap2;

  int unsigned checks = 0;
  int unsigned passed = 0;

  decoder_seq_n #(.SEL_W(3), .DWELL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in(in), .load(load),
    .dwell(dwell), .out(out), .idx(idx), .valid(valid), .wrap(wrap)
  );

  decoder_seq_n #(.SEL_W(4), .DWELL_W(4)) dut16 (
    .clk(clk), .rst_n(rst2_n), .en(en2), .mode(mode2), .in(in2), .load(load2),
    .dwell(dwell2), .out(out2), .idx(idx2), .valid(valid2), .wrap(wrap2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] e_out, input logic e_wrap);
    chk({tag, ".out"}, 64'(out), 64'(e_out));
    chk({tag, ".wrap"}, 64'(wrap), 64'(e_wrap));
  endtask

  logic [15:0] seen;
  logic [7:0]  e8;

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = 1'b1; in = 3'd5; load = 1'b0; dwell = 4'd0;
    rst2_n = 1'b0; en2 = 1'b0; mode2 = 1'b0; in2 = '0; load2 = 1'b0; dwell2 = '0;

    // Reset overrides an active scan request.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst.out", 64'(out), 64'h00);
      chk("rst.idx", 64'(idx), 64'd0);
      chk("rst.valid", 64'(valid), 64'd0);
      chk("rst.wrap", 64'(wrap), 64'd0);
    end

    // Direct sweep over {en,in}.
    rst_n = 1'b1; mode = 1'b0;
    for (int i = 0; i < 16; i++) begin
      en = i[3];
      in = i[2:0];
      step();
      e8 = 8'h00;
      if (i >= 8) e8[i-8] = 1'b1;
      chk("dir.out", 64'(out), 64'(e8));
      chk("dir.valid", 64'(valid), 64'(i >= 8));
      chk("dir.idx", 64'(idx), (i >= 8) ? 64'(i - 8) : 64'd0);
      chk("dir.wrap", 64'(wrap), 64'd0);
    end

    // Scan with dwell=0 starting at 6.
    mode = 1'b1; in = 3'd6; dwell = 4'd0;
    step(); chk8("scan0.e", 8'h40, 1'b0);
    step(); chk8("scan0.7", 8'h80, 1'b0);
    step(); chk8("scan0.w1", 8'h01, 1'b1);
    for (int k = 1; k < 8; k++) begin
      step();
      e8 = 8'h00; e8[k] = 1'b1;
      chk8("scan0.run", e8, 1'b0);
    end
    step(); chk8("scan0.w2", 8'h01, 1'b1);

    // en falling clears everything on the next edge.
    en = 1'b0;
    step();
    chk8("off", 8'h00, 1'b0);
    chk("off.valid", 64'(valid), 64'd0);
    chk("off.idx", 64'(idx), 64'd0);

    // Scan with dwell=2, changed to 0 in the middle of line 1.
    en = 1'b1; in = 3'd0; dwell = 4'd2;
    step(); chk8("dw.l0a", 8'h01, 1'b0);
    step(); chk8("dw.l0b", 8'h01, 1'b0);
    step(); chk8("dw.l0c", 8'h01, 1'b0);
    step(); chk8("dw.l1a", 8'h02, 1'b0);
    step(); chk8("dw.l1b", 8'h02, 1'b0);
    dwell = 4'd0;
    step(); chk8("dw.l1c", 8'h02, 1'b0);
    step(); chk8("dw.l2", 8'h04, 1'b0);
    step(); chk8("dw.l3", 8'h08, 1'b0);

    // Load priority, then switch to direct mode.
    dwell = 4'd1; load = 1'b1; in = 3'd2;
    step(); chk8("ld.start", 8'h04, 1'b0);
    load = 1'b0;
    step(); chk8("ld.hold", 8'h04, 1'b0);
    load = 1'b1; in = 3'd4;
    step(); chk8("ld.prio", 8'h10, 1'b0);
    chk("ld.idx", 64'(idx), 64'd4);
    load = 1'b0;
    step(); chk8("ld.restart", 8'h10, 1'b0);
    mode = 1'b0; in = 3'd1;
    step(); chk8("ld.direct", 8'h02, 1'b0);
    chk("ld.direct.valid", 64'(valid), 64'd1);

    // 16-line scan from 0 with dwell=0, then a mid-scan reset.
    rst2_n = 1'b1; en2 = 1'b1; mode2 = 1'b1; in2 = 4'd0; dwell2 = 4'd0;
    seen = '0;
    for (int k = 0; k < 16; k++) begin
      step();
      chk("s16.out", 64'(out2), 64'(16'(1) << k));
      chk("s16.wrap", 64'(wrap2), 64'd0);
      seen = seen | out2;
    end
    chk("s16.distinct", 64'(seen), 64'hffff);
    step();
    chk("s16.w1", 64'(out2), 64'h0001);
    chk("s16.w1.wrap", 64'(wrap2), 64'd1);
    for (int k = 1; k < 16; k++) begin
      step();
      chk("s16.run.wrap", 64'(wrap2), 64'd0);
    end
    step();
    chk("s16.w2", 64'(out2), 64'h0001);
    chk("s16.w2.wrap", 64'(wrap2), 64'd1);
    for (int k = 1; k < 10; k++) step();
    chk("s16.at9", 64'(idx2), 64'd9);
    rst2_n = 1'b0; in2 = 4'd3;
    step();
    chk("s16.rst.out", 64'(out2), 64'h0000);
    chk("s16.rst.valid", 64'(valid2), 64'd0);
    rst2_n = 1'b1;
    step();
    chk("s16.resume", 64'(out2), 64'h0008);
    chk("s16.resume.idx", 64'(idx2), 64'd3);
    step();
    chk("s16.resume.next", 64'(out2), 64'h0010);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
